// File: rtl/zap_fifo_wr_arbiter.sv
// zap_fifo_wr_arbiter
// Round-robin, burst-based write-side arbiter that shares one synchronous FIFO
// among NREQ requesters. It also sequences FIFO flushes by holding off writes,
// issuing a one-cycle clear and then pulsing a completion strobe.
//
// Ports
//   i_clk          clock, all state changes on the rising edge
//   i_reset        synchronous active-high reset
//   i_req          per-requester beat offer (one beat per cycle while high)
//   i_last         marks the offered beat as the final one of the burst
//   i_data         requester k's data word in bits [k*WIDTH +: WIDTH]
//   o_ack          beat accepted this cycle (one-hot or zero)
//   o_gnt          registered one-hot grant, zero outside GRANT
//   i_fifo_full    FIFO full flag
//   o_fifo_wr_en   FIFO write enable
//   o_fifo_data    FIFO write data (granted requester's word, else zero)
//   i_flush        flush request, level sampled every cycle
//   o_fifo_clear   one-cycle FIFO clear
//   o_flush_done   one-cycle pulse once the flush has completed
//   o_busy         high whenever the arbiter is not idle
module zap_fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 4
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [NREQ-1:0]         i_req,
  input  logic [NREQ-1:0]         i_last,
  input  logic [NREQ*WIDTH-1:0]   i_data,
  output logic [NREQ-1:0]         o_ack,
  output logic [NREQ-1:0]         o_gnt,
  input  logic                    i_fifo_full,
  output logic                    o_fifo_wr_en,
  output logic [WIDTH-1:0]        o_fifo_data,
  input  logic                    i_flush,
  output logic                    o_fifo_clear,
  output logic                    o_flush_done,
  output logic                    o_busy
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(MAX_BURST) + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]   last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [IW-1:0]    win_idx_s;
  logic             win_found_s;
  logic [NREQ-1:0]  win_oh_s;
  logic             req_g_s;
  logic             last_g_s;
  logic [WIDTH-1:0] data_g_s;

  // Round-robin search starting one past the last winner and wrapping.
  always_comb begin : arb_search
    logic [IW-1:0] cand;
    logic          hit;
    cand        = '0;
    hit         = 1'b0;
    win_idx_s   = '0;
    win_found_s = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      cand        = IW'((int'(last_q) + k) % NREQ);
      hit         = ~win_found_s & i_req[cand];
      win_idx_s   = hit ? cand : win_idx_s;
      win_found_s = win_found_s | hit;
    end
    win_oh_s = {{(NREQ-1){1'b0}}, 1'b1} << win_idx_s;
  end

  // Select the granted requester's request, last flag and data word.
  always_comb begin
    req_g_s  = |(i_req & gnt_q);
    last_g_s = |(i_last & gnt_q);
    data_g_s = '0;
    for (int k = 0; k < NREQ; k++) begin
      data_g_s = data_g_s | (gnt_q[k] ? i_data[k*WIDTH +: WIDTH] : {WIDTH{1'b0}});
    end
  end

  // Next-state logic plus the combinational beat outputs.
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    o_ack        = '0;
    o_fifo_wr_en = 1'b0;
    o_fifo_data  = '0;
    case (state_q)
      ST_IDLE: begin
        if (i_flush) begin
          state_d = ST_FLUSH;
        end else if (win_found_s) begin
          state_d = ST_GRANT;
          gnt_d   = win_oh_s;
          last_d  = win_idx_s;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        o_fifo_data = data_g_s;
        if (i_flush) begin
          // Flush wins over any offered beat; the burst is abandoned.
          state_d = ST_FLUSH;
          gnt_d   = '0;
        end else if (!req_g_s) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
        end else if (!i_fifo_full) begin
          o_ack        = gnt_q;
          o_fifo_wr_en = 1'b1;
          cnt_d        = cnt_q + CW'(1);
          if (last_g_s || (cnt_q == CW'(MAX_BURST - 1))) begin
            state_d = ST_IDLE;
            gnt_d   = '0;
          end else begin
            state_d = ST_GRANT;
          end
        end else begin
          // FIFO full: stall, grant and beat count held.
          state_d = ST_GRANT;
        end
      end
      ST_FLUSH: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State, grant, round-robin pointer and beat counter registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      last_q  <= IW'(NREQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_gnt        = gnt_q;
  assign o_busy       = (state_q != ST_IDLE);
  assign o_fifo_clear = (state_q == ST_FLUSH);
  assign o_flush_done = (state_q == ST_DONE);

endmodule

// File: tb/tb_zap_fifo_wr_arbiter.sv
module tb_zap_fifo_wr_arbiter;

  localparam int NREQ      = 4;
  localparam int WIDTH     = 32;
  localparam int MAX_BURST = 4;

  logic                  i_clk;
  logic                  i_reset;
  logic [NREQ-1:0]       i_req;
  logic [NREQ-1:0]       i_last;
  logic [NREQ*WIDTH-1:0] i_data;
  logic [NREQ-1:0]       o_ack;
  logic [NREQ-1:0]       o_gnt;
  logic                  i_fifo_full;
  logic                  o_fifo_wr_en;
  logic [WIDTH-1:0]      o_fifo_data;
  logic                  i_flush;
  logic                  o_fifo_clear;
  logic                  o_flush_done;
  logic                  o_busy;

  int n_checks = 0;
  int n_pass   = 0;
  logic [WIDTH-1:0] sb_q[$];

  zap_fifo_wr_arbiter #(
    .NREQ(NREQ), .WIDTH(WIDTH), .MAX_BURST(MAX_BURST)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_req(i_req), .i_last(i_last),
    .i_data(i_data), .o_ack(o_ack), .o_gnt(o_gnt), .i_fifo_full(i_fifo_full),
    .o_fifo_wr_en(o_fifo_wr_en), .o_fifo_data(o_fifo_data), .i_flush(i_flush),
    .o_fifo_clear(o_fifo_clear), .o_flush_done(o_flush_done), .o_busy(o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_data(input int k, input logic [WIDTH-1:0] v);
    i_data[k*WIDTH +: WIDTH] = v;
  endtask

  // Check one cycle's outputs, queue expected FIFO writes, then advance.
  task automatic cyc(input string tag, input logic [NREQ-1:0] exp_gnt,
                     input logic [NREQ-1:0] exp_ack, input logic exp_clr,
                     input logic exp_done, input logic exp_busy);
    logic [WIDTH-1:0] exp_data;
    #1;
    exp_data = '0;
    for (int k = 0; k < NREQ; k++)
      if (exp_gnt[k]) exp_data = i_data[k*WIDTH +: WIDTH];
    chk({tag, "_gnt"},  64'(o_gnt), 64'(exp_gnt));
    chk({tag, "_ack"},  64'(o_ack), 64'(exp_ack));
    chk({tag, "_wren"}, 64'(o_fifo_wr_en), 64'(|exp_ack));
    chk({tag, "_data"}, 64'(o_fifo_data), 64'(exp_data));
    chk({tag, "_clr"},  64'(o_fifo_clear), 64'(exp_clr));
    chk({tag, "_done"}, 64'(o_flush_done), 64'(exp_done));
    chk({tag, "_busy"}, 64'(o_busy), 64'(exp_busy));
    for (int k = 0; k < NREQ; k++)
      if (exp_ack[k]) sb_q.push_back(i_data[k*WIDTH +: WIDTH]);
    tick();
  endtask

  // FIFO-side monitor: every write is popped against the scoreboard.
  always @(negedge i_clk) begin
    if (!i_reset) begin
      if (i_fifo_full) chk("wr_while_full", 64'(o_fifo_wr_en), 64'd0);
      if (o_fifo_wr_en) begin
        chk("ack_onehot", 64'($onehot(o_ack)), 64'd1);
        if (sb_q.size() == 0) chk("sb_unexpected_write", 64'd1, 64'd0);
        else chk("sb_data", 64'(o_fifo_data), 64'(sb_q.pop_front()));
      end
    end
  end

  initial begin
    i_reset = 1'b1; i_req = '0; i_last = '0; i_fifo_full = 1'b0; i_flush = 1'b0;
    for (int k = 0; k < NREQ; k++) set_data(k, 32'hDEAD_0000 + 32'(k));
    tick(); tick();
    cyc("rst", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    i_reset = 1'b0;

    // Single requester, 6-beat burst split by MAX_BURST.
    i_req = 4'b0001; set_data(0, 32'hA000_0001);
    cyc("s1_arb", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    for (int b = 1; b <= 4; b++) begin
      set_data(0, 32'hA000_0000 + 32'(b));
      cyc("s1_beat", 4'b0001, 4'b0001, 1'b0, 1'b0, 1'b1);
    end
    set_data(0, 32'hA000_0005);
    cyc("s1_bubble", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    cyc("s1_b5", 4'b0001, 4'b0001, 1'b0, 1'b0, 1'b1);
    set_data(0, 32'hA000_0006); i_last = 4'b0001;
    cyc("s1_b6", 4'b0001, 4'b0001, 1'b0, 1'b0, 1'b1);
    i_req = '0; i_last = '0;
    cyc("s1_end", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);

    i_reset = 1'b1; tick(); i_reset = 1'b0;

    // All four requesting, one-beat bursts: order 0,1,2,3,0.
    i_req = 4'b1111; i_last = 4'b1111;
    for (int k = 0; k < NREQ; k++) set_data(k, 32'hB000_0000 + 32'(k));
    for (int i = 0; i < 5; i++) begin
      cyc("s2_idle", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
      cyc("s2_gnt", 4'b0001 << (i % 4), 4'b0001 << (i % 4), 1'b0, 1'b0, 1'b1);
    end
    i_req = '0; i_last = '0;
    cyc("s2_end", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);

    // Requester 2 stalled by a full FIFO mid-burst.
    i_req = 4'b0100; set_data(2, 32'hC000_0001);
    cyc("s3_arb", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    cyc("s3_b1", 4'b0100, 4'b0100, 1'b0, 1'b0, 1'b1);
    set_data(2, 32'hC000_0002); i_fifo_full = 1'b1;
    repeat (3) cyc("s3_stall", 4'b0100, 4'b0000, 1'b0, 1'b0, 1'b1);
    i_fifo_full = 1'b0;
    cyc("s3_b2", 4'b0100, 4'b0100, 1'b0, 1'b0, 1'b1);
    set_data(2, 32'hC000_0003);
    cyc("s3_b3", 4'b0100, 4'b0100, 1'b0, 1'b0, 1'b1);
    set_data(2, 32'hC000_0004);
    cyc("s3_b4", 4'b0100, 4'b0100, 1'b0, 1'b0, 1'b1);
    i_req = '0;
    cyc("s3_max", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);

    // Flush during GRANT with a beat on offer.
    i_req = 4'b0010; set_data(1, 32'hD000_0001);
    cyc("s4_arb", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    cyc("s4_b1", 4'b0010, 4'b0010, 1'b0, 1'b0, 1'b1);
    set_data(1, 32'hD000_0002); i_flush = 1'b1;
    cyc("s4_flush", 4'b0010, 4'b0000, 1'b0, 1'b0, 1'b1);
    i_flush = 1'b0; i_req = '0;
    cyc("s4_clear", 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1);
    cyc("s4_done", 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1);

    // Pointer kept across flush (last=1): requesters 1,2 -> 2 wins.
    i_req = 4'b0110; i_last = 4'b0100;
    set_data(1, 32'hE100_0001); set_data(2, 32'hE200_0001);
    cyc("s5_arb", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    cyc("s5_g2", 4'b0100, 4'b0100, 1'b0, 1'b0, 1'b1);
    i_req = 4'b0010; i_last = '0;
    cyc("s5_bubble", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    cyc("s5_b1", 4'b0010, 4'b0010, 1'b0, 1'b0, 1'b1);
    set_data(1, 32'hE100_0002);
    cyc("s5_b2", 4'b0010, 4'b0010, 1'b0, 1'b0, 1'b1);
    i_req = '0;
    cyc("s5_drop", 4'b0010, 4'b0000, 1'b0, 1'b0, 1'b1);
    i_req = 4'b1010; i_last = 4'b1000; set_data(3, 32'hE300_0001);
    cyc("s5_idle", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    cyc("s5_g3", 4'b1000, 4'b1000, 1'b0, 1'b0, 1'b1);
    i_req = '0; i_last = '0;
    cyc("s5_end", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);

    // Flush from IDLE, then reset while in FLUSH.
    i_flush = 1'b1;
    cyc("s6_flush", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    i_flush = 1'b0; i_reset = 1'b1;
    cyc("s6_clear", 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1);
    i_reset = 1'b0;
    repeat (3) cyc("s6_after_rst", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);

    chk("sb_leftover", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
